// File: rtl/calc_pkg.sv
// Shared constants, state encoding and command bundle for calc_ctrl.
package calc_pkg;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h04;
  localparam logic [4:0] OP_DIV = 5'h08;

  localparam logic [3:0] DT_UNSIGNED = 4'h1;
  localparam logic [3:0] DT_SIGNED   = 4'h2;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_R  = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_SEND,
    ST_ERR
  } state_e;

  typedef struct packed {
    logic [3:0]  dtype;
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  function automatic logic cmd_ok(
    input logic [4:0]  op,
    input logic [15:0] b
  );
    logic known;
    known = (op == OP_ADD) || (op == OP_SUB) ||
            (op == OP_MUL) || (op == OP_DIV);
    return known && !((op == OP_DIV) && (b == 16'h0));
  endfunction

endpackage

// File: rtl/calc_ctrl_nibble_to_ascii.sv
// Combinational 4-bit value to uppercase hex ASCII character.
module nibble_to_ascii (
  input  logic [3:0] nib,
  output logic [7:0] ch
);

  always_comb begin
    ch = 8'h00;
    unique case (1'b1)
      (nib < 4'd10):  ch = 8'h30 + {4'h0, nib};
      (nib >= 4'd10): ch = 8'h37 + {4'h0, nib};
      default:        ch = 8'h00;
    endcase
  end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: decoder -> ALU handshake -> hex/ERR
// string out to the UART TX byte interface.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        dec_done,
  input  logic [3:0]  dec_dtype,
  input  logic [4:0]  dec_op,
  input  logic [15:0] dec_src1,
  input  logic [15:0] dec_src2,
  output logic        alu_start,
  output logic [4:0]  alu_op,
  output logic        alu_signed,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        lost,
  output logic        timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic [31:0]     res_q, res_d;
  logic [3:0]      idx_q, idx_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic            lost_q, lost_d;
  logic            timeout_q, timeout_d;

  logic            in_send;
  logic            in_err;
  logic [4:0]      sh;
  logic [31:0]     res_sh;
  logic [7:0]      hex_ch;
  logic [7:0]      tx_byte;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      lost_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      lost_q    <= lost_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    res_d     = res_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    lost_d    = dec_done && (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (dec_done) begin
          cmd_d.dtype = dec_dtype;
          cmd_d.op    = dec_op;
          cmd_d.a     = dec_src1;
          cmd_d.b     = dec_src2;
          idx_d       = 4'd0;
          state_d     = cmd_ok(dec_op, dec_src2) ?
                        ST_ISSUE : ST_ERR;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // a done arriving on the expiry cycle still wins
        if (alu_done) begin
          res_d   = alu_result;
          idx_d   = 4'd0;
          state_d = ST_SEND;
        end else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          idx_d     = 4'd0;
          state_d   = ST_ERR;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx_q == 4'd9) begin
            idx_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_ERR: begin
        if (tx_ready) begin
          if (idx_q == 4'd4) begin
            idx_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_send = (state_q == ST_SEND);
  assign in_err  = (state_q == ST_ERR);
  assign sh      = 5'd28 - {idx_q[2:0], 2'b00};
  assign res_sh  = res_q >> sh;

  nibble_to_ascii u_hex (
    .nib (res_sh[3:0]),
    .ch  (hex_ch)
  );

  always_comb begin
    tx_byte = 8'h00;
    unique case (1'b1)
      in_send && !idx_q[3]:         tx_byte = hex_ch;
      in_send && (idx_q == 4'd8):   tx_byte = CH_CR;
      in_send && (idx_q == 4'd9):   tx_byte = CH_LF;
      in_err && (idx_q == 4'd0):    tx_byte = CH_E;
      in_err && (idx_q == 4'd1):    tx_byte = CH_R;
      in_err && (idx_q == 4'd2):    tx_byte = CH_R;
      in_err && (idx_q == 4'd3):    tx_byte = CH_CR;
      in_err && (idx_q == 4'd4):    tx_byte = CH_LF;
      default:                      tx_byte = 8'h00;
    endcase
  end

  assign alu_start  = (state_q == ST_ISSUE);
  assign alu_op     = cmd_q.op;
  assign alu_signed = (cmd_q.dtype == DT_SIGNED);
  assign alu_a      = cmd_q.a;
  assign alu_b      = cmd_q.b;
  assign tx_valid   = in_send || in_err;
  assign tx_data    = tx_byte;
  assign busy       = (state_q != ST_IDLE);
  assign lost       = lost_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: directed cases then random
// transactions against a behavioural calculator model.
module tb_calc_ctrl;
  import calc_pkg::*;

  localparam int TO = 64;

  logic        clk;
  logic        n_rst;
  logic        dec_done;
  logic [3:0]  dec_dtype;
  logic [4:0]  dec_op;
  logic [15:0] dec_src1;
  logic [15:0] dec_src2;
  logic        alu_start;
  logic [4:0]  alu_op;
  logic        alu_signed;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_done;
  logic [31:0] alu_result;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        lost;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int stall_at = -1;
  bit bp_en = 0;
  logic [7:0] exp_q[$];

  calc_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .dec_done   (dec_done),
    .dec_dtype  (dec_dtype),
    .dec_op     (dec_op),
    .dec_src1   (dec_src1),
    .dec_src2   (dec_src2),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_signed (alu_signed),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .lost       (lost),
    .timeout    (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(
    input logic [4:0]  op,
    input bit          sg,
    input logic [15:0] a,
    input logic [15:0] b
  );
    longint x, y, r;
    x = sg ? longint'($signed(a)) : longint'(a);
    y = sg ? longint'($signed(b)) : longint'(b);
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_MUL:  r = x * y;
      OP_DIV:  r = (y == 0) ? 0 : x / y;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic chk_idle(input string tag);
    check({tag, "_alu_start"}, alu_start, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_alu_signed"}, alu_signed, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_lost"}, lost, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic monitor();
    bit pst;
    logic [7:0] pd;
    logic [7:0] e;
    pst = 0;
    pd = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        pst = 0;
      end else begin
        if (pst) begin
          check("hold_valid", tx_valid, 1);
          check("hold_data", tx_data, pd);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_extra: got %h, expected none",
                     tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", tx_data, e);
          end
          acc_cnt++;
        end
        pst = tx_valid && !tx_ready;
        pd = tx_data;
      end
    end
  endtask

  task automatic ready_drv();
    int left;
    int last;
    left = 0;
    last = -1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_at >= 0 && acc_cnt == stall_at &&
          last != stall_at) begin
        left = 3;
        last = stall_at;
      end
      if (left > 0) begin
        tx_ready = 1'b0;
        left--;
      end else begin
        tx_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  endtask

  task automatic run_txn(
    input logic [4:0]  op,
    input logic [3:0]  dt,
    input logic [15:0] a,
    input logic [15:0] b,
    input int          dly,
    input bit          ovl,
    input int          stall_after,
    input int          rst_after
  );
    logic [31:0] r;
    bit ok, sg, err, done;
    string s;
    int base, first, pulses, nbytes;
    ok = (op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV}) &&
         !(op == OP_DIV && b == 16'h0);
    sg = (dt == DT_SIGNED);
    r = ref_alu(op, sg, a, b);
    err = !ok || dly < 0;
    if (err) begin
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h52);
      exp_q.push_back(8'h52);
      nbytes = 5;
    end else begin
      s = $sformatf("%08h", r);
      s = s.toupper();
      for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
      nbytes = 10;
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    base = acc_cnt;
    stall_at = (stall_after >= 0) ? base + stall_after : -1;

    @(posedge clk);
    #1;
    dec_done = 1'b1;
    dec_op = op;
    dec_dtype = dt;
    dec_src1 = a;
    dec_src2 = b;
    @(posedge clk);
    #1;
    dec_done = 1'b0;
    @(negedge clk);
    check("busy_after_done", busy, 1);
    if (!ok) begin
      check("no_alu_start", alu_start, 0);
    end else begin
      check("alu_start", alu_start, 1);
      check("alu_op", alu_op, op);
      check("alu_signed", alu_signed, sg);
      check("alu_a", alu_a, a);
      check("alu_b", alu_b, b);
      if (ovl) begin
        @(posedge clk);
        #1;
        dec_done = 1'b1;
        dec_op = OP_ADD;
        dec_src1 = ~a;
        dec_src2 = ~b;
        @(posedge clk);
        #1;
        dec_done = 1'b0;
        @(negedge clk);
        check("lost_pulse", lost, 1);
        check("ovl_alu_a", alu_a, a);
        check("ovl_alu_b", alu_b, b);
        @(negedge clk);
        check("lost_end", lost, 0);
      end else begin
        @(negedge clk);
        check("alu_start_pulse", alu_start, 0);
      end
      if (dly >= 0) begin
        repeat (dly) @(posedge clk);
        #1;
        alu_result = r;
        alu_done = 1'b1;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        alu_result = $urandom;
      end else begin
        first = -1;
        pulses = 0;
        for (int k = 2; k <= TO + 4; k++) begin
          @(negedge clk);
          alu_done = (k == TO + 2);
          if (timeout) begin
            pulses++;
            if (first < 0) first = k;
          end
        end
        alu_done = 1'b0;
        check("timeout_at", first, TO + 1);
        check("timeout_pulses", pulses, 1);
      end
    end

    if (rst_after >= 0) begin
      done = 0;
      for (int c = 0; c < 400 && !done; c++) begin
        @(posedge clk);
        #1;
        done = (acc_cnt - base >= rst_after);
      end
      check("rst_reached", done, 1);
      n_rst = 1'b0;
      #1;
      chk_idle("midrst");
      exp_q.delete();
      stall_at = -1;
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      return;
    end

    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      #1;
      done = !busy && exp_q.size() == 0;
    end
    check("drain_in_time", done, 1);
    check("transfers", acc_cnt - base, nbytes);
    check("tx_valid_idle", tx_valid, 0);
    if (!done) exp_q.delete();
    stall_at = -1;
  endtask

  initial begin
    logic [4:0] ops [6];
    logic [4:0] op;
    logic [15:0] b;
    ops[0] = OP_ADD;
    ops[1] = OP_SUB;
    ops[2] = OP_MUL;
    ops[3] = OP_DIV;
    ops[4] = 5'h03;
    ops[5] = 5'h10;
    n_rst = 1'b0;
    dec_done = 1'b0;
    dec_dtype = '0;
    dec_op = '0;
    dec_src1 = '0;
    dec_src2 = '0;
    alu_done = 1'b0;
    alu_result = '0;
    tx_ready = 1'b1;
    fork
      monitor();
      ready_drv();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    run_txn(OP_ADD, DT_UNSIGNED, 16'h1234, 16'h0011,
            3, 0, -1, -1);
    run_txn(OP_DIV, DT_UNSIGNED, 16'h0005, 16'h0000,
            3, 0, -1, -1);
    run_txn(OP_SUB, DT_SIGNED, 16'h0001, 16'h0003,
            2, 0, 3, -1);
    run_txn(OP_ADD, DT_UNSIGNED, 16'h0007, 16'h0008,
            -1, 0, -1, -1);
    run_txn(OP_MUL, DT_UNSIGNED, 16'h0102, 16'h0304,
            6, 1, -1, -1);
    run_txn(OP_ADD, DT_UNSIGNED, 16'hABCD, 16'h1111,
            2, 0, -1, 4);
    run_txn(OP_ADD, DT_UNSIGNED, 16'hFFFF, 16'h0001,
            3, 0, -1, -1);

    bp_en = 1;
    for (int t = 0; t < 25; t++) begin
      op = ops[$urandom_range(0, 5)];
      b = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      run_txn(op, 4'($urandom_range(1, 2)), 16'($urandom), b,
              $urandom_range(1, 12), 0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
